// File: rtl/bus_master_port_pkg.sv
// Shared definitions for the serial bus master port: instruction codes,
// FSM state encoding and default widths.
package bus_master_port_pkg;

   localparam int ADDR_WIDTH_DEF = 12;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int SEL_WIDTH_DEF  = 2;
   localparam int TIMEOUT_DEF    = 255;

   localparam logic [1:0] INSTR_IDLE  = 2'b00;
   localparam logic [1:0] INSTR_READ  = 2'b01;
   localparam logic [1:0] INSTR_WRITE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_ADDR  = 3'd2,
      ST_WDATA = 3'd3,
      ST_WACK  = 3'd4,
      ST_RDATA = 3'd5,
      ST_DONE  = 3'd6
   } state_t;

   // Reserved code 11 behaves like idle, so only 01 and 10 launch a request.
   function automatic logic is_request(input logic [1:0] instr);
      return (instr == INSTR_READ) || (instr == INSTR_WRITE);
   endfunction

endpackage

// File: rtl/bus_master_port_piso_sipo.sv
// Shift register shared by the serialiser and deserialiser: parallel load,
// shift right (out of bit 0 / in at the MSB) and a count of bits moved.
module bus_piso_sipo #(
   parameter int W  = 14,
   parameter int DW = 8,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [W-1:0]  load_val_i,
   input  logic          shift_out_i,
   input  logic          shift_in_i,
   input  logic          sin_i,
   output logic          sout_o,
   output logic [CW-1:0] cnt_o,
   output logic [DW-1:0] pnext_o
);

   logic [W-1:0]  q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q   <= '0;
         cnt_q <= '0;
      end else begin
         q_q   <= q_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      if (load_i) begin
         q_d   = load_val_i;
         cnt_d = '0;
      end else if (shift_out_i || shift_in_i) begin
         q_d   = {shift_in_i & sin_i, q_q[W-1:1]};
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign sout_o  = q_q[0];
   assign cnt_o   = cnt_q;
   // Received word as it will look once the bit on sin_i is shifted in.
   assign pnext_o = {sin_i, q_q[W-1 -: DW-1]};

endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: arbitrates for the bus, sends select/address/data LSB
// first, collects read data, and closes with a four-phase tx_done handshake.
module bus_master_port
   import bus_master_port_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            instruction,
   input  logic [SEL_WIDTH-1:0]  slave_sel,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  tx_done,
   output logic                  tx_error,
   output logic                  bus_req,
   input  logic                  bus_grant,
   output logic                  m_valid,
   output logic                  m_bit,
   output logic                  m_mode,
   input  logic                  s_ready,
   input  logic                  s_valid,
   input  logic                  s_bit,
   output state_t                dbg_state_o
);

   localparam int ABITS  = SEL_WIDTH + ADDR_WIDTH;
   localparam int SR_W   = (ABITS > DATA_WIDTH) ? ABITS : DATA_WIDTH;
   localparam int CNT_W  = $clog2(SR_W + 1);
   localparam int TOUT_W = $clog2(TIMEOUT + 1);

   state_t                state_q, state_d;
   logic                  mode_q, mode_d;
   logic [SEL_WIDTH-1:0]  sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [TOUT_W-1:0]     tout_q, tout_d;

   logic             sr_load, sr_shift_out, sr_shift_in, sr_sout;
   logic [SR_W-1:0]  sr_load_val;
   logic [CNT_W-1:0] sr_cnt;
   logic [DATA_WIDTH-1:0] sr_pnext;

   logic last_abit, last_dbit, tout_expired;

   assign last_abit    = (sr_cnt == CNT_W'(ABITS - 1));
   assign last_dbit    = (sr_cnt == CNT_W'(DATA_WIDTH - 1));
   assign tout_expired = (tout_q == TOUT_W'(TIMEOUT - 1));

   bus_piso_sipo #(
      .W  (SR_W),
      .DW (DATA_WIDTH),
      .CW (CNT_W)
   ) u_shift (
      .clk         (clk),
      .reset       (reset),
      .load_i      (sr_load),
      .load_val_i  (sr_load_val),
      .shift_out_i (sr_shift_out),
      .shift_in_i  (sr_shift_in),
      .sin_i       (s_bit),
      .sout_o      (sr_sout),
      .cnt_o       (sr_cnt),
      .pnext_o     (sr_pnext)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Grant loss outranks every other exit from the active states.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (is_request(instruction)) state_d = ST_REQ;
         ST_REQ:   if (bus_grant) state_d = ST_ADDR;
         ST_ADDR: begin
            if (!bus_grant)     state_d = ST_DONE;
            else if (last_abit) state_d = mode_q ? ST_WDATA : ST_RDATA;
         end
         ST_WDATA: begin
            if (!bus_grant)     state_d = ST_DONE;
            else if (last_dbit) state_d = ST_WACK;
         end
         ST_WACK: begin
            if (!bus_grant || s_ready || tout_expired) state_d = ST_DONE;
         end
         ST_RDATA: begin
            if (!bus_grant || (s_valid && last_dbit) || (!s_valid && tout_expired))
               state_d = ST_DONE;
         end
         ST_DONE:  if (instruction == INSTR_IDLE) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mode_d       = mode_q;
      sel_d        = sel_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      tout_d       = '0;
      sr_load      = 1'b0;
      sr_load_val  = '0;
      sr_shift_out = 1'b0;
      sr_shift_in  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            err_d = 1'b0;
            if (is_request(instruction)) begin
               mode_d  = (instruction == INSTR_WRITE);
               sel_d   = slave_sel;
               addr_d  = address;
               wdata_d = data_in;
            end
         end
         ST_REQ: begin
            if (bus_grant) begin
               sr_load     = 1'b1;
               sr_load_val = SR_W'({addr_q, sel_q});
            end
         end
         ST_ADDR: begin
            if (!bus_grant) begin
               err_d = 1'b1;
            end else if (last_abit) begin
               sr_load     = 1'b1;
               sr_load_val = mode_q ? SR_W'(wdata_q) : '0;
            end else begin
               sr_shift_out = 1'b1;
            end
         end
         ST_WDATA: begin
            if (!bus_grant) err_d = 1'b1;
            else            sr_shift_out = 1'b1;
         end
         ST_WACK: begin
            if (!bus_grant)        err_d = 1'b1;
            else if (s_ready)      err_d = 1'b0;
            else if (tout_expired) err_d = 1'b1;
            else                   tout_d = tout_q + TOUT_W'(1);
         end
         ST_RDATA: begin
            if (!bus_grant) begin
               err_d = 1'b1;
            end else if (s_valid) begin
               sr_shift_in = 1'b1;
               if (last_dbit) rdata_d = sr_pnext;
            end else if (tout_expired) begin
               err_d = 1'b1;
            end else begin
               tout_d = tout_q + TOUT_W'(1);
            end
         end
         ST_DONE: if (instruction == INSTR_IDLE) err_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q  <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         tout_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         tout_q  <= tout_d;
      end
   end

   // Strobes decode straight from the state register, so reset clears them at once.
   always_comb begin
      bus_req = (state_q inside {ST_REQ, ST_ADDR, ST_WDATA, ST_WACK, ST_RDATA});
      m_valid = (state_q inside {ST_ADDR, ST_WDATA});
      tx_done = (state_q == ST_DONE);
      m_bit   = m_valid & sr_sout;
   end

   assign m_mode      = mode_q;
   assign tx_error    = err_q;
   assign data_out    = rdata_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: serial bits and completions are checked
// by a negedge monitor against queues filled when each request is issued.
module tb_bus_master_port;
   import bus_master_port_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] instruction = 2'b00;
   logic [1:0] slave_sel = '0;
   logic [11:0] address = '0;
   logic [7:0] data_in = '0;
   logic [7:0] data_out;
   logic       tx_done, tx_error, bus_req, m_valid, m_bit, m_mode;
   logic       bus_grant = 1'b0;
   logic       s_ready = 1'b0, s_valid = 1'b0, s_bit = 1'b0;
   state_t     dbg_state;

   int checks = 0;
   int errors = 0;

   logic [1:0] exp_bit_q[$];   // {m_mode, m_bit}
   logic [8:0] exp_resp_q[$];  // {tx_error, data_out}
   logic [7:0] exp_data = '0;
   logic       done_prev = 1'b0;

   bus_master_port dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .slave_sel   (slave_sel),
      .address     (address),
      .data_in     (data_in),
      .data_out    (data_out),
      .tx_done     (tx_done),
      .tx_error    (tx_error),
      .bus_req     (bus_req),
      .bus_grant   (bus_grant),
      .m_valid     (m_valid),
      .m_bit       (m_bit),
      .m_mode      (m_mode),
      .s_ready     (s_ready),
      .s_valid     (s_valid),
      .s_bit       (s_bit),
      .dbg_state_o (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_bits(input logic [31:0] v, input int n, input logic mode);
      for (int i = 0; i < n; i++) exp_bit_q.push_back({mode, v[i]});
   endtask

   task automatic wait_state(input state_t s, input int max_cycles, input string name);
      int n = 0;
      while (dbg_state != s && n < max_cycles) begin
         tick();
         n++;
      end
      check(name, 32'(dbg_state), 32'(s));
   endtask

   task automatic wait_done(input int max_cycles, input string name);
      int n = 0;
      while (!tx_done && n < max_cycles) begin
         tick();
         n++;
      end
      check(name, 32'(tx_done), 32'd1);
   endtask

   task automatic close_req();
      instruction = INSTR_IDLE;
      tick();
   endtask

   // Monitor: every strobed bit and every tx_done rise consumes one expectation.
   always @(negedge clk) begin
      if (reset) begin
         done_prev = 1'b0;
      end else begin
         if (m_valid) begin
            if (exp_bit_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_bit: got m_bit=%0b with no bit expected", m_bit);
            end else begin
               logic [1:0] e;
               e = exp_bit_q.pop_front();
               check("m_bit", 32'(m_bit), 32'(e[0]));
               check("m_mode", 32'(m_mode), 32'(e[1]));
            end
         end
         if (tx_done && !done_prev) begin
            if (exp_resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got tx_done with no completion expected");
            end else begin
               logic [8:0] r;
               r = exp_resp_q.pop_front();
               check("tx_error", 32'(tx_error), 32'(r[8]));
               check("data_out", 32'(data_out), 32'(r[7:0]));
            end
         end
         done_prev = tx_done;
      end
   end

   initial begin
      int n;
      logic [7:0] rd;

      // Reset state
      repeat (3) tick();
      check("reset_outputs", 32'({bus_req, m_valid, m_bit, m_mode, tx_done, tx_error, data_out}), 32'd0);
      check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
      reset = 1'b0;
      tick();

      // Write sel=01 addr=0x0A5 data=0x3C; {addr,sel}=0x295
      instruction = INSTR_WRITE; slave_sel = 2'b01; address = 12'h0A5; data_in = 8'h3C;
      push_bits(32'h295, 14, 1'b1);
      push_bits(32'h3C, 8, 1'b1);
      exp_resp_q.push_back({1'b0, exp_data});
      tick();
      check("w1_req_state", 32'(dbg_state), 32'(ST_REQ));
      check("w1_bus_req", 32'(bus_req), 32'd1);
      slave_sel = 2'b11; address = 12'h000; data_in = 8'hFF;
      repeat (3) tick();
      check("w1_wait_grant", 32'(dbg_state), 32'(ST_REQ));
      bus_grant = 1'b1;
      wait_state(ST_WACK, 40, "w1_reach_wack");
      check("w1_wack_mvalid", 32'(m_valid), 32'd0);
      tick(); tick();
      s_ready = 1'b1;
      wait_done(5, "w1_done");
      s_ready = 1'b0;

      // Handshake hold while instruction stays at write
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_tx_done", 32'(tx_done), 32'd1);
         check("hold_no_bus_req", 32'(bus_req), 32'd0);
      end
      close_req();
      check("release_tx_done", 32'(tx_done), 32'd0);
      check("release_state", 32'(dbg_state), 32'(ST_IDLE));

      // Read sel=10 addr=0xFFF; {addr,sel}=0x3FFE; slave returns 0x96 with a gap
      instruction = INSTR_READ; slave_sel = 2'b10; address = 12'hFFF; data_in = 8'h00;
      push_bits(32'h3FFE, 14, 1'b0);
      exp_data = 8'h96;
      exp_resp_q.push_back({1'b0, exp_data});
      tick();
      wait_state(ST_RDATA, 30, "r_reach_rdata");
      rd = 8'h96;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_bit   = rd[i];
         tick();
         if (i == 2) begin
            s_valid = 1'b0;
            s_bit   = 1'b1;
            tick();
         end
      end
      s_valid = 1'b0;
      s_bit   = 1'b0;
      wait_done(3, "r_done");
      check("r_data_out", 32'(data_out), 32'h96);
      close_req();

      // Write with no s_ready: timeout after 255 cycles in WACK; {0x123,00}=0x48C
      instruction = INSTR_WRITE; slave_sel = 2'b00; address = 12'h123; data_in = 8'h5A;
      push_bits(32'h48C, 14, 1'b1);
      push_bits(32'h5A, 8, 1'b1);
      exp_resp_q.push_back({1'b1, exp_data});
      tick();
      wait_state(ST_WACK, 40, "to_reach_wack");
      n = 0;
      while (!tx_done && n < 400) begin
         tick();
         n++;
      end
      check("to_cycles", 32'(n), 32'd255);
      check("to_tx_error", 32'(tx_error), 32'd1);
      check("to_bus_req", 32'(bus_req), 32'd0);
      close_req();

      // Grant lost while address bit 5 is on the wire; {0x000,11}=0x003
      instruction = INSTR_WRITE; slave_sel = 2'b11; address = 12'h000; data_in = 8'h00;
      push_bits(32'h003, 6, 1'b1);
      exp_resp_q.push_back({1'b1, exp_data});
      tick();
      wait_state(ST_ADDR, 5, "gl_reach_addr");
      repeat (5) tick();
      bus_grant = 1'b0;
      tick();
      check("gl_m_valid", 32'(m_valid), 32'd0);
      check("gl_tx_done", 32'(tx_done), 32'd1);
      check("gl_tx_error", 32'(tx_error), 32'd1);
      bus_grant = 1'b1;
      close_req();
      check("gl_error_cleared", 32'(tx_error), 32'd0);

      // Reserved instruction never requests the bus
      instruction = 2'b11;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("rsvd_bus_req", 32'(bus_req), 32'd0);
      end
      check("rsvd_state", 32'(dbg_state), 32'(ST_IDLE));
      close_req();

      // Reset while data bit 3 is on the wire; {0x0FF,01}=0x3FD, data 0xA5
      instruction = INSTR_WRITE; slave_sel = 2'b01; address = 12'h0FF; data_in = 8'hA5;
      push_bits(32'h3FD, 14, 1'b1);
      push_bits(32'hA5, 3, 1'b1);
      tick();
      wait_state(ST_WDATA, 30, "rst_reach_wdata");
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check("rst_outputs", 32'({bus_req, m_valid, m_bit, m_mode, tx_done, tx_error, data_out}), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      exp_data = 8'h00;
      instruction = INSTR_IDLE;
      tick(); tick();
      reset = 1'b0;
      check("rst_bits_consumed", 32'(exp_bit_q.size()), 32'd0);
      tick();

      // Normal write after reset; {0x456,10}=0x115A, data 0xC3
      instruction = INSTR_WRITE; slave_sel = 2'b10; address = 12'h456; data_in = 8'hC3;
      push_bits(32'h115A, 14, 1'b1);
      push_bits(32'hC3, 8, 1'b1);
      exp_resp_q.push_back({1'b0, exp_data});
      tick();
      wait_state(ST_WACK, 40, "w2_reach_wack");
      s_ready = 1'b1;
      wait_done(3, "w2_done");
      s_ready = 1'b0;
      close_req();

      tick(); tick();
      check("end_bits_left", 32'(exp_bit_q.size()), 32'd0);
      check("end_resp_left", 32'(exp_resp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
